// File: rtl/axi_write_burst_master_pkg.sv
// Shared AXI3 encodings and FSM states for the write-burst master.
package axi_write_burst_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  // True when the last word of the burst would land in the next 4KB page.
  function automatic logic crosses_4k(input logic [9:0] word_idx, input logic [3:0] len);
    logic [10:0] sum;
    sum = {1'b0, word_idx} + {7'd0, len};
    return sum[10];
  endfunction

endpackage

// File: rtl/axi_wr_beat_gen.sv
// Beat counter, incrementing write data and wlast for one INCR burst.
module axi_wr_beat_gen (
  input  logic        aclk,
  input  logic        areset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic [3:0]  len,
  input  logic        active,
  input  logic        advance,
  output logic [31:0] wrdata,
  output logic        wlast
);

  logic [31:0] seed_q;
  logic [3:0]  len_q;
  logic [3:0]  beat;

  always_ff @(posedge aclk) begin
    if (areset) begin
      seed_q <= 32'd0;
      len_q  <= 4'd0;
      beat   <= 4'd0;
    end else if (load) begin
      seed_q <= seed;
      len_q  <= len;
      beat   <= 4'd0;
    end else if (advance) begin
      beat <= beat + 4'd1;
    end
  end

  assign wrdata = seed_q + {28'd0, beat};
  // Gated by active so an idle bus never shows a stray wlast.
  assign wlast  = active && (beat == len_q);

endmodule

// File: rtl/axi_write_burst_master.sv
// AXI3 single-burst write master; define AXI_WR_BID_CHECK_EN to flag
// responses whose bid does not match the issued ID as SLVERR.
module axi_write_burst_master
  import axi_write_burst_master_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 256,
  parameter logic [3:0] WSTRB_VAL      = 4'hF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] cmd_data,
  output logic        done_valid,
  output logic [1:0]  done_resp,
  output logic [3:0]  awid,
  output logic [31:0] awadr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wrdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [1:0]      resp_sel;
  logic            unused_addr;

  assign unused_addr = ^cmd_addr[1:0];

`ifdef AXI_WR_BID_CHECK_EN
  always_comb begin
    resp_sel = bresp;
    if (bid != awid) resp_sel = RESP_SLVERR;
  end
`else
  logic unused_bid;
  assign unused_bid = ^bid;
  always_comb begin
    resp_sel = bresp;
  end
`endif

  axi_wr_beat_gen u_beat_gen (
    .aclk    (aclk),
    .areset  (areset),
    .load    (state == ST_IDLE && cmd_valid),
    .seed    (cmd_data),
    .len     (cmd_len),
    .active  (wvalid),
    .advance (wvalid && wready),
    .wrdata  (wrdata),
    .wlast   (wlast)
  );

  // Each phase raises only its own valid/ready, so AW, W and B never overlap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      done_valid <= 1'b0;
      done_resp  <= RESP_OKAY;
      awid       <= 4'd0;
      awadr      <= 32'd0;
      awlen      <= 4'd0;
      awsize     <= 3'd0;
      awburst    <= 2'd0;
      awvalid    <= 1'b0;
      wid        <= 4'd0;
      wstrb      <= 4'd0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      timer      <= '0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            awid      <= cmd_id;
            wid       <= cmd_id;
            awadr     <= {cmd_addr[31:2], 2'b00};
            awlen     <= cmd_len;
            if (crosses_4k(cmd_addr[11:2], cmd_len)) begin
              done_valid <= 1'b1;
              done_resp  <= RESP_SLVERR;
              state      <= ST_DONE;
            end else begin
              awsize  <= SIZE_4B;
              awburst <= BURST_INCR;
              awvalid <= 1'b1;
              state   <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wstrb   <= WSTRB_VAL;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wready && wlast) begin
            wvalid <= 1'b0;
            wstrb  <= 4'd0;
            bready <= 1'b1;
            timer  <= '0;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            done_valid <= 1'b1;
            done_resp  <= resp_sel;
            state      <= ST_DONE;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            bready     <= 1'b0;
            done_valid <= 1'b1;
            done_resp  <= RESP_DECERR;
            state      <= ST_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_DONE: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_burst_master.sv
// Directed self-checking bench for axi_write_burst_master (TIMEOUT_CYCLES=16).
module tb_axi_write_burst_master;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_data;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic [3:0]  awid;
  logic [31:0] awadr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total = 0;
  int bad   = 0;

  axi_write_burst_master #(.TIMEOUT_CYCLES(16), .WSTRB_VAL(4'hF)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_data(cmd_data),
    .done_valid(done_valid), .done_resp(done_resp),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [3:0] l,
                               input logic [3:0] id, input logic [31:0] d);
    cmd_valid = v;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_id    = id;
    cmd_data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hs;
    int cnt;
    logic [31:0] exp_data;
    logic [1:0]  exp_mis;

    areset = 1'b1;
    applyStimulus(1'b0, 32'd0, 4'd0, 4'd0, 32'd0);
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'b00;
    tick(); tick();
    areset = 1'b0;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_done", {done_valid, done_resp}, 0);
    checkOutput("rst_wlast", wlast, 0);

    $display("[TB] basic burst");
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bid = 4'd5; bresp = 2'b00;
    applyStimulus(1'b1, 32'h100, 4'd3, 4'd5, 32'h10);
    tick();
    cmd_valid = 1'b0;
    checkOutput("t1_awvalid", awvalid, 1);
    checkOutput("t1_awadr", awadr, 32'h100);
    checkOutput("t1_awlen", awlen, 3);
    checkOutput("t1_awid", awid, 5);
    checkOutput("t1_awsize", awsize, 3'b010);
    checkOutput("t1_awburst", awburst, 2'b01);
    checkOutput("t1_cmd_ready", cmd_ready, 0);
    checkOutput("t1_wvalid_in_addr", wvalid, 0);
    tick();
    checkOutput("t1_awvalid_drop", awvalid, 0);
    checkOutput("t1_wid", wid, 5);
    checkOutput("t1_wstrb", wstrb, 4'hF);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t1_wvalid", wvalid, 1);
      checkOutput("t1_wrdata", wrdata, 32'h10 + k);
      checkOutput("t1_wlast", wlast, (k == 3) ? 1 : 0);
      tick();
    end
    checkOutput("t1_resp_bready", bready, 1);
    checkOutput("t1_resp_wvalid", wvalid, 0);
    tick();
    checkOutput("t1_done", {done_valid, done_resp}, 3'b100);
    checkOutput("t1_done_bready", bready, 0);
    tick();
    checkOutput("t1_idle_done", done_valid, 0);
    checkOutput("t1_idle_ready", cmd_ready, 1);

    $display("[TB] wready toggling");
    applyStimulus(1'b1, 32'h100, 4'd3, 4'd5, 32'h10);
    tick();
    cmd_valid = 1'b0;
    tick();
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      if (!wvalid) break;
      wready = (c % 2 == 0);
      checkOutput("t2_wrdata", wrdata, 32'h10 + hs);
      checkOutput("t2_wlast", wlast, (hs == 3) ? 1 : 0);
      if (wready) hs++;
      tick();
    end
    checkOutput("t2_handshakes", hs, 4);
    checkOutput("t2_bready", bready, 1);
    wready = 1'b1;
    tick();
    checkOutput("t2_done", {done_valid, done_resp}, 3'b100);
    tick();

    $display("[TB] 4KB crossing");
    applyStimulus(1'b1, 32'hFF8, 4'd3, 4'd2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("t3_awvalid", awvalid, 0);
    checkOutput("t3_done", {done_valid, done_resp}, 3'b110);
    tick();
    checkOutput("t3_awvalid2", awvalid, 0);
    checkOutput("t3_done_clear", done_valid, 0);
    checkOutput("t3_ready", cmd_ready, 1);

    $display("[TB] response timeout");
    bvalid = 1'b0;
    applyStimulus(1'b1, 32'h200, 4'd0, 4'd1, 32'hAA);
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("t4_single_wlast", wlast, 1);
    tick();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bready) break;
      cnt++;
      tick();
    end
    checkOutput("t4_resp_cycles", cnt, 16);
    checkOutput("t4_done", {done_valid, done_resp}, 3'b111);
    tick();
    checkOutput("t4_ready", cmd_ready, 1);
    checkOutput("t4_resp_hold", done_resp, 2'b11);

    $display("[TB] data wrap");
    bvalid = 1'b1; bresp = 2'b01; bid = 4'd3;
    applyStimulus(1'b1, 32'h300, 4'd2, 4'd3, 32'hFFFFFFFE);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_data = (k == 0) ? 32'hFFFFFFFE : (k == 1) ? 32'hFFFFFFFF : 32'h00000000;
      checkOutput("t5_wrdata", wrdata, exp_data);
      checkOutput("t5_wlast", wlast, (k == 2) ? 1 : 0);
      tick();
    end
    tick();
    checkOutput("t5_done", {done_valid, done_resp}, 3'b101);
    tick();

    $display("[TB] reset mid-burst");
    bresp = 2'b00; bid = 4'd4;
    applyStimulus(1'b1, 32'h400, 4'd7, 4'd4, 32'h50);
    tick();
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    checkOutput("t6_beat2", wrdata, 32'h52);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checkOutput("t6_wvalid", wvalid, 0);
    checkOutput("t6_ready", cmd_ready, 1);
    checkOutput("t6_wlast", wlast, 0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("t6_no_done", done_valid, 0);
      tick();
    end

    $display("[TB] awready stall and bid mismatch");
`ifdef AXI_WR_BID_CHECK_EN
    exp_mis = 2'b10;
`else
    exp_mis = 2'b00;
`endif
    awready = 1'b0; bid = 4'd6; bresp = 2'b00;
    applyStimulus(1'b1, 32'h504, 4'd0, 4'd5, 32'h77);
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checkOutput("t7_aw_hold", awvalid, 1);
      checkOutput("t7_awadr_hold", awadr, 32'h504);
      checkOutput("t7_no_wvalid", wvalid, 0);
      tick();
    end
    awready = 1'b1;
    tick();
    checkOutput("t7_wdata", wrdata, 32'h77);
    tick();
    tick();
    checkOutput("t7_bid_resp", {done_valid, done_resp}, {1'b1, exp_mis});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
